// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Optional return-address stack is enabled with the PCSEQ_RAS_EN macro.
package pcseq_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [7:0] PC_RESET  = 8'h00;
    localparam logic [7:0] STALL_MAX = 8'hFF;

    // Stall counter increment that holds at STALL_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == STALL_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between control unit / program counter (master) and the sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 4
);
    import pcseq_pkg::*;

    logic        [PC_W-1:0]  PCout;
    logic                    Branch;
    logic                    Zero;
    logic signed [OFF_W-1:0] BranchOffset;
    logic                    Jump;
    logic                    Call;
    logic                    Ret;
    logic        [PC_W-1:0]  JumpTarget;
    logic                    Halt;
    logic                    Resume;
    logic                    MemBusy;
    logic        [PC_W-1:0]  PCin;
    logic                    PCWrite;
    logic                    Halted;
    logic        [7:0]       StallCount;
    logic                    RasOvf;
    logic                    RasUnf;

    modport master (
        output PCout, Branch, Zero, BranchOffset, Jump, Call, Ret, JumpTarget,
               Halt, Resume, MemBusy,
        input  PCin, PCWrite, Halted, StallCount, RasOvf, RasUnf
    );

    modport slave (
        input  PCout, Branch, Zero, BranchOffset, Jump, Call, Ret, JumpTarget,
               Halt, Resume, MemBusy,
        output PCin, PCWrite, Halted, StallCount, RasOvf, RasUnf
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry; a pop from an empty stack leaves the pointer alone.
module pcseq_ras
    import pcseq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            ovf_o,
    output logic            unf_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Pointer, occupancy and sticky flags for the next edge.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q == (PTR_W+1)'(DEPTH)) ovf_d = 1'b1;
            else                            cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (pop_i) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - (PTR_W+1)'(1);
            end
        end
    end

    // Control state; cleared by Reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; only the pointer marks what is valid, so no reset.
    always_ff @(posedge Clock) begin
        if (push_i) mem_q[ptr_q] <= push_data_i;
    end

    assign top_o   = mem_q[ptr_q - PTR_W'(1)];
    assign empty_o = (cnt_q == '0);
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with run/halt control and stall counting.
// Define PCSEQ_RAS_EN to add the return-address stack (Call/Ret);
// without it Call acts as Jump and Ret as a plain increment.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 4,
    parameter int RAS_DEPTH = 4
) (
    input logic           Clock,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of 2 and at least 2");
    end

    state_e             state_q, state_d;
    logic [7:0]         stall_q, stall_d;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_br;
    logic signed [PC_W-1:0] off_ext;
    logic [PC_W-1:0]    pc_in;
    logic               pc_write;

    assign pc_inc  = bus.PCout + PC_W'(1);
    assign off_ext = {{(PC_W-OFF_W){bus.BranchOffset[OFF_W-1]}}, bus.BranchOffset};
    assign pc_br   = pc_inc + $unsigned(off_ext);

`ifdef PCSEQ_RAS_EN
    logic            ras_push, ras_pop, ras_empty;
    logic [PC_W-1:0] ras_top;

    pcseq_ras #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .Clock       (Clock),
        .Reset       (Reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .ovf_o       (bus.RasOvf),
        .unf_o       (bus.RasUnf)
    );
`else
    assign bus.RasOvf = 1'b0;
    assign bus.RasUnf = 1'b0;
`endif

    // Next state, next PC, write enable and stack requests for this cycle.
    always_comb begin
        state_d  = state_q;
        stall_d  = stall_q;
        pc_in    = pc_inc;
        pc_write = 1'b0;
`ifdef PCSEQ_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        if (!Reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.MemBusy) stall_d = sat_inc8(stall_q);
                    if (bus.Halt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_write = !bus.MemBusy;
                        if (bus.Ret) begin
`ifdef PCSEQ_RAS_EN
                            pc_in   = ras_empty ? PC_W'(PC_RESET) : ras_top;
                            ras_pop = !bus.MemBusy;
`else
                            pc_in   = pc_inc;
`endif
                        end else if (bus.Call) begin
                            pc_in = bus.JumpTarget;
`ifdef PCSEQ_RAS_EN
                            ras_push = !bus.MemBusy;
`endif
                        end else if (bus.Jump) begin
                            pc_in = bus.JumpTarget;
                        end else if (bus.Branch && bus.Zero) begin
                            pc_in = pc_br;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.Resume) begin
                        pc_write = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Run/halt state and stall counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_RUN;
            stall_q <= 8'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign bus.PCin       = pc_in;
    assign bus.PCWrite    = pc_write;
    assign bus.Halted     = (state_q == ST_HALT);
    assign bus.StallCount = stall_q;

endmodule
